deparser: RTL and testbench
===========================

DEPARSER -- requirements
Module: deparser

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32: width of one header word; equals the memory data bus width.
REQ-002 SHALL have parameter NUM_HEADERS, default 8: number of header slots in the header vector.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32: memory address width.
REQ-004 SHALL have parameter BASE_ADDR, default 0: packet buffer start address.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 Ports SHALL be:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous active-low reset.
- start_i  in  1  job request; a job starts on a 0->1 transition.
- parsed_hdrs_i  in  WORD_WIDTH*NUM_HEADERS  header vector; slot k is bits [k*WORD_WIDTH +: WORD_WIDTH].
- hdr_valid_i  in  NUM_HEADERS  per-slot valid mask.
- mem_ce_o  out  1  memory access enable.
- mem_we_o  out  1  memory write, 1 = write.
- mem_addr_o  out  ADDR_WIDTH  byte address.
- mem_width_o  out  4  access size in bytes.
- mem_data_o  out  WORD_WIDTH  write data.
- mem_data_i  in  WORD_WIDTH  read data, valid the cycle after the read is issued.
- ready_o  out  1  idle and able to accept a start.
- done_o  out  1  one-cycle job-complete pulse.
- len_o  out  ADDR_WIDTH  bytes written by the last job.
- err_o  out  1  readback mismatch, sticky.

Function
REQ-007 SHALL register start_i into start_q; a start event SHALL be start_i=1 while start_q=0 and the state is IDLE; start events in any other state SHALL be ignored.
REQ-008 On a start event, SHALL capture parsed_hdrs_i and hdr_valid_i into internal registers, set the write pointer to BASE_ADDR, clear len_o and err_o, and enter WRITE.
REQ-009 FSM states SHALL be IDLE, WRITE, RD, CMP and DONE; RD and CMP exist only when readback is enabled.
REQ-010 In WRITE, SHALL select the lowest-index captured-valid slot not yet emitted.
- SHALL drive mem_ce_o=1, mem_we_o=1, mem_width_o=4'd4, mem_addr_o=pointer, mem_data_o=slot word for exactly that cycle.
- SHALL then add 4 to the pointer and to len_o.
REQ-011 Invalid slots SHALL be skipped with no cycle penalty, so the output is compacted: N valid slots give N consecutive write cycles.
REQ-012 When no unemitted valid slot remains, SHALL enter DONE; DONE SHALL assert done_o for one cycle, then return to IDLE.
REQ-013 Zero valid slots SHALL go WRITE -> DONE with no memory access and len_o=0.
REQ-014 Latency without readback: start edge at cycle 0; writes in cycles 1..N; done_o at cycle N+1.
REQ-015 Outside an active access, mem_ce_o, mem_we_o, mem_addr_o, mem_width_o and mem_data_o SHALL be 0.
REQ-016 The pointer SHALL wrap modulo 2^ADDR_WIDTH.
REQ-017 ready_o SHALL be 1 only in IDLE; len_o SHALL hold its value until the next start event.
REQ-018 Input changes to parsed_hdrs_i or hdr_valid_i after capture SHALL NOT affect the running job.

Reset
REQ-019 While rst=0, SHALL force IDLE and start_q=1, so start_i held high through reset does not start a job.
REQ-020 While rst=0, all outputs SHALL be 0, except ready_o, which SHALL be 1 once in IDLE.
REQ-021 Reset mid-job SHALL abort immediately (mem_ce_o drops asynchronously) with no done_o pulse.

Configuration
REQ-022 With DEPARSER_READBACK_EN defined, each WRITE cycle SHALL be followed by:
- RD: same address, mem_ce_o=1, mem_we_o=0, width 4.
- CMP: compare mem_data_i with the written word; a mismatch sets err_o until the next start event.
- Per word this is 3 cycles; done_o is at cycle 3N+1.
REQ-023 Without DEPARSER_READBACK_EN, there SHALL be no RD or CMP states, mem_data_i SHALL be unused, and err_o SHALL be tied to 0.

Structure
REQ-024 Package deparser_pkg SHALL hold the state enum, MEM_WIDTH_WORD=4'd4 and WORD_BYTES=4.
REQ-025 SHALL use sub-module hdr_pick: combinational lowest-set-bit finder over (valid mask AND NOT emitted mask), outputting index and found flag.

Verification
REQ-026 Valid mask 8'hFF, slot k=32'hA0000000+k, BASE_ADDR=0 -> writes 0x0..0x1C in 8 consecutive cycles; done_o at cycle 9; len_o=32.
REQ-027 Valid mask 8'b1010_0101 -> slots 0,2,5,7 written at 0x0,0x4,0x8,0xC back-to-back; len_o=16.
REQ-028 Valid mask 8'h00 -> no mem_ce_o; done_o at cycle 2; len_o=0.
REQ-029 start_i held high across reset release, then pulsed again after done_o -> exactly one job, started by the second pulse; second start held high during the job is ignored.
REQ-030 rst asserted during the 3rd write -> mem_ce_o=0 immediately, no done_o, ready_o=1; the next start runs a complete job.
REQ-031 With DEPARSER_READBACK_EN, sram byte 0x4 corrupted between WR and RD -> err_o=1 from the CMP of slot 1, held through done_o; the next clean job clears err_o.

Source files
------------

// File: rtl/deparser_pkg.sv
// Deparser shared definitions: FSM state encoding and memory access constants.
// The RD/CMP states exist only when DEPARSER_READBACK_EN is defined.
package deparser_pkg;

  localparam logic [3:0] MEM_WIDTH_WORD = 4'd4;
  localparam int         WORD_BYTES     = 4;

`ifdef DEPARSER_READBACK_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD,
    ST_CMP,
    ST_DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DONE
  } state_t;
`endif

endpackage

// File: rtl/deparser_hdr_pick.sv
// hdr_pick: combinational lowest-set-bit finder over the header slots that are
// valid but not yet emitted. Returns the slot index and a found flag.
module hdr_pick #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     valid_i,
  input  logic [N-1:0]     emitted_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  logic [N-1:0] rem;
  assign rem = valid_i & ~emitted_i;

  // Scan from the top so the lowest remaining slot wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rem[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/deparser.sv
// deparser: writes the valid header slots of a captured header vector to a
// packet buffer as a compacted run of word writes starting at BASE_ADDR.
// Optional feature macro: DEPARSER_READBACK_EN -- every write is followed by a
// read of the same address and a compare; mismatches set a sticky err_o.
module deparser
  import deparser_pkg::*;
#(
  parameter int                    WORD_WIDTH  = 32,
  parameter int                    NUM_HEADERS = 8,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_i,
  input  logic [WORD_WIDTH*NUM_HEADERS-1:0] parsed_hdrs_i,
  input  logic [NUM_HEADERS-1:0]            hdr_valid_i,
  output logic                              mem_ce_o,
  output logic                              mem_we_o,
  output logic [ADDR_WIDTH-1:0]             mem_addr_o,
  output logic [3:0]                        mem_width_o,
  output logic [WORD_WIDTH-1:0]             mem_data_o,
  input  logic [WORD_WIDTH-1:0]             mem_data_i,
  output logic                              ready_o,
  output logic                              done_o,
  output logic [ADDR_WIDTH-1:0]             len_o,
  output logic                              err_o
);

  localparam int                    IDX_W = (NUM_HEADERS > 1) ? $clog2(NUM_HEADERS) : 1;
  localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(WORD_BYTES);

  state_t state_q, state_d;

  logic                                   start_q;
  logic [NUM_HEADERS-1:0][WORD_WIDTH-1:0] hdrs_q;
  logic [NUM_HEADERS-1:0]                 valid_q;
  logic [NUM_HEADERS-1:0]                 emitted_q;
  logic [ADDR_WIDTH-1:0]                  ptr_q;
  logic [ADDR_WIDTH-1:0]                  len_q;

  logic                   start_ev;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_found;
  logic [NUM_HEADERS-1:0] pick_oh;
  logic [WORD_WIDTH-1:0]  pick_word;

  assign start_ev  = start_i & ~start_q & (state_q == ST_IDLE);
  assign pick_oh   = pick_found ? (NUM_HEADERS'(1) << pick_idx) : '0;
  assign pick_word = hdrs_q[pick_idx];

  hdr_pick #(
    .N     (NUM_HEADERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid_i   (valid_q),
    .emitted_i (emitted_q),
    .idx_o     (pick_idx),
    .found_o   (pick_found)
  );

`ifdef DEPARSER_READBACK_EN
  logic [WORD_WIDTH-1:0] wdata_q;
  logic                  err_q;
  assign err_o = err_q;
`else
  // Anything left after the slot being written decides WRITE vs DONE.
  logic more_after;
  assign more_after = |(valid_q & ~emitted_q & ~pick_oh);
  logic unused_rdata;
  assign unused_rdata = ^mem_data_i;
  assign err_o = 1'b0;
`endif

  // State register; reset aborts any job at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ev) state_d = ST_WRITE;
      ST_WRITE: begin
        if (!pick_found) state_d = ST_DONE;
        else begin
`ifdef DEPARSER_READBACK_EN
          state_d = ST_RD;
`else
          state_d = more_after ? ST_WRITE : ST_DONE;
`endif
        end
      end
`ifdef DEPARSER_READBACK_EN
      ST_RD:    state_d = ST_CMP;
      // The written slot is already marked emitted, so found means more work.
      ST_CMP:   state_d = pick_found ? ST_WRITE : ST_DONE;
`endif
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Memory bus and status outputs, decoded from the current state.
  always_comb begin
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_width_o = 4'd0;
    mem_data_o  = '0;
    ready_o     = (state_q == ST_IDLE);
    done_o      = (state_q == ST_DONE);
    case (state_q)
      ST_WRITE: begin
        if (pick_found) begin
          mem_ce_o    = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = ptr_q;
          mem_width_o = MEM_WIDTH_WORD;
          mem_data_o  = pick_word;
        end
      end
`ifdef DEPARSER_READBACK_EN
      ST_RD: begin
        mem_ce_o    = 1'b1;
        mem_addr_o  = ptr_q;
        mem_width_o = MEM_WIDTH_WORD;
      end
`endif
      default: ;
    endcase
  end

  // Job datapath: capture on start, then track emitted slots, pointer and length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q   <= 1'b1;
      hdrs_q    <= '0;
      valid_q   <= '0;
      emitted_q <= '0;
      ptr_q     <= BASE_ADDR;
      len_q     <= '0;
`ifdef DEPARSER_READBACK_EN
      wdata_q   <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      start_q <= start_i;
      if (start_ev) begin
        hdrs_q    <= parsed_hdrs_i;
        valid_q   <= hdr_valid_i;
        emitted_q <= '0;
        ptr_q     <= BASE_ADDR;
        len_q     <= '0;
`ifdef DEPARSER_READBACK_EN
        err_q     <= 1'b0;
`endif
      end else begin
        if (state_q == ST_WRITE && pick_found) begin
          emitted_q <= emitted_q | pick_oh;
          len_q     <= len_q + STEP;
`ifdef DEPARSER_READBACK_EN
          wdata_q   <= pick_word;
`else
          ptr_q     <= ptr_q + STEP;
`endif
        end
`ifdef DEPARSER_READBACK_EN
        // Pointer advances only after the readback so RD reuses the write address.
        if (state_q == ST_CMP) begin
          ptr_q <= ptr_q + STEP;
          if (mem_data_i != wdata_q) err_q <= 1'b1;
        end
`endif
      end
    end
  end

  assign len_o = len_q;

endmodule

// File: tb/tb_deparser.sv
// Self-checking bench for deparser: directed and random jobs checked against a
// slot-list model; includes a word-addressed SRAM model for readback builds.
module tb_deparser;

  localparam int W  = 32;
  localparam int NH = 8;
  localparam int AW = 32;
`ifdef DEPARSER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic            clk, rst, start_i;
  logic [W*NH-1:0] parsed_hdrs_i;
  logic [NH-1:0]   hdr_valid_i;
  logic            mem_ce_o, mem_we_o;
  logic [AW-1:0]   mem_addr_o;
  logic [3:0]      mem_width_o;
  logic [W-1:0]    mem_data_o, mem_data_i;
  logic            ready_o, done_o, err_o;
  logic [AW-1:0]   len_o;

  int n_assert = 0;
  int n_fail   = 0;
  int corrupt_word = -1;

  deparser #(.WORD_WIDTH(W), .NUM_HEADERS(NH), .ADDR_WIDTH(AW), .BASE_ADDR('0)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .parsed_hdrs_i(parsed_hdrs_i), .hdr_valid_i(hdr_valid_i),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_width_o(mem_width_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .ready_o(ready_o), .done_o(done_o), .len_o(len_o), .err_o(err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Packet buffer: writes land next edge, reads return data the following cycle.
  logic [W-1:0] sram [0:63];
  logic [W-1:0] rdata_q = '0;
  assign mem_data_i = rdata_q;
  always @(posedge clk) begin
    if (mem_ce_o) begin
      if (mem_we_o)
        sram[mem_addr_o[7:2]] <= (int'(mem_addr_o[7:2]) == corrupt_word) ? (mem_data_o ^ 32'h1) : mem_data_o;
      else
        rdata_q <= sram[mem_addr_o[7:2]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_ce", mem_ce_o, 0);
      chk("idle_ready", ready_o, 1);
      chk("idle_done", done_o, 0);
    end
  endtask

  // Run one job and check every cycle against the expected compacted slot list.
  task automatic run_job(input logic [NH-1:0] mask, input logic [W*NH-1:0] hdrs,
                         input int corrupt, input bit wiggle, input bit hold, input bit poke);
    logic [W-1:0] exp_q[$];
    int n, exp_done, wr, rd;
    bit done_seen, err_job;
    for (int k = 0; k < NH; k++)
      if (mask[k]) exp_q.push_back(hdrs[k*W +: W]);
    n        = exp_q.size();
    exp_done = (n == 0) ? 2 : (RB ? 3*n + 1 : n + 1);
    err_job  = RB && corrupt >= 0 && corrupt < n;
    corrupt_word = corrupt;
    wr = 0; rd = 0; done_seen = 0;
    @(negedge clk);
    parsed_hdrs_i = hdrs;
    hdr_valid_i   = mask;
    start_i       = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 40 && !done_seen; c++) begin
      @(negedge clk);
      if (wiggle) begin
        parsed_hdrs_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        hdr_valid_i   = NH'($urandom);
      end
      if (poke && c == 2) start_i = 1'b0;
      if (poke && c == 3) start_i = 1'b1;
      if (mem_ce_o && mem_we_o) begin
        chk("wr_cycle", c, RB ? 1 + 3*wr : 1 + wr);
        chk("wr_addr", mem_addr_o, 4*wr);
        chk("wr_width", mem_width_o, 4);
        chk("wr_data", mem_data_o, (wr < n) ? exp_q[wr] : 'x);
        wr++;
      end else if (mem_ce_o) begin
        chk("rd_enabled", RB, 1);
        chk("rd_cycle", c, 2 + 3*rd);
        chk("rd_addr", mem_addr_o, 4*rd);
        chk("rd_width", mem_width_o, 4);
        rd++;
      end else begin
        chk("bus_quiet", {mem_we_o, mem_width_o, mem_addr_o, mem_data_o[26:0]}, 0);
      end
      if (err_job) begin
        if (c <= 3*corrupt + 3) chk("err_early", err_o, 0);
        else                    chk("err_set", err_o, 1);
      end else begin
        chk("err_clear", err_o, 0);
      end
      if (!done_o) chk("ready_busy", ready_o, 0);
      if (done_o) begin
        done_seen = 1;
        chk("done_cycle", c, exp_done);
        chk("len_final", len_o, 4*n);
      end
    end
    chk("done_seen", done_seen, 1);
    chk("write_count", wr, n);
    if (!hold) start_i = 1'b0;
    @(negedge clk);
    chk("ready_after", ready_o, 1);
    chk("done_pulse_once", done_o, 0);
    chk("len_hold", len_o, 4*n);
    chk("err_hold", err_o, err_job);
    corrupt_word = -1;
  endtask

  function automatic logic [W*NH-1:0] rand_hdrs();
    logic [W*NH-1:0] h;
    for (int k = 0; k < NH; k++) h[k*W +: W] = $urandom;
    return h;
  endfunction

  initial begin
    logic [W*NH-1:0] hseq;
    int writes;
    rst = 1'b0; start_i = 1'b1; parsed_hdrs_i = '0; hdr_valid_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_ce", mem_ce_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_width", mem_width_o, 0);
    chk("rst_data", mem_data_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_len", len_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_ready", ready_o, 1);
    rst = 1'b1;
    // start held high across reset release must not launch a job
    idle_cycles(5);
    start_i = 1'b0;
    @(negedge clk);

    // all slots valid, start held and re-pulsed mid-job
    for (int k = 0; k < NH; k++) hseq[k*W +: W] = 32'hA000_0000 + k;
    run_job(8'hFF, hseq, -1, 0, 1, 1);
    idle_cycles(4);
    start_i = 1'b0;

    run_job(8'b1010_0101, rand_hdrs(), -1, 1, 0, 0);
    run_job(8'h00, rand_hdrs(), -1, 0, 0, 0);
    run_job(8'h80, rand_hdrs(), -1, 1, 0, 0);
    run_job(8'h01, rand_hdrs(), -1, 0, 0, 0);
    for (int j = 0; j < 6; j++)
      run_job(NH'($urandom), rand_hdrs(), -1, 1, 0, 0);

    // reset during the third write aborts immediately
    @(negedge clk);
    parsed_hdrs_i = rand_hdrs(); hdr_valid_i = 8'hFF; start_i = 1'b1;
    @(posedge clk);
    writes = 0;
    for (int c = 1; c <= 40 && writes < 3; c++) begin
      @(negedge clk);
      if (mem_ce_o && mem_we_o) writes++;
    end
    chk("abort_reach", writes, 3);
    #2 rst = 1'b0;
    #1;
    chk("abort_ce", mem_ce_o, 0);
    chk("abort_done", done_o, 0);
    chk("abort_ready", ready_o, 1);
    @(negedge clk);
    start_i = 1'b0;
    chk("abort_done2", done_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle_cycles(2);
    run_job(8'hFF, rand_hdrs(), -1, 0, 0, 0);

    if (RB) begin
      run_job(8'hFF, hseq, 1, 0, 0, 0);
      run_job(8'hFF, hseq, -1, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
